fazyrv_alu_seq: RTL and testbench

Self-contained chunked ALU engine: accepts full-width operand pairs over a valid/ready request port, processes them LSB-first in CHUNKSIZE-bit slices over XLEN/CHUNKSIZE cycles, and returns the full-width result and compare flag over a valid/ready response port. It generalises the FazyRV chunked ALU datapath with configurable XLEN, internal operand/result shift registers, internally generated lsb/msb sequencing, back-pressure, and illegal-op reporting. It is intended as a standalone coprocessor-style ALU and as the golden chunk-sequencing reference for core-level formal benches.

---
 rtl/fazyrv_alu_seq_if.sv | 30 +++
 rtl/fazyrv_alu_seq.sv | 209 ++++++++++++++++++++
 tb/tb_fazyrv_alu_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fazyrv_alu_seq_if.sv
// Request/response bundle of the chunked ALU engine.
//   req_valid_i / req_ready_o : request handshake
//   req_op_i, req_a_i, req_b_i: operation and full-width operands
//   rsp_valid_o / rsp_ready_i : response handshake
//   rsp_res_o, rsp_cmp_o, rsp_illegal_o : full-width result, compare flag, illegal-op flag
// Signal names keep the engine-side direction suffixes; the slave modport is the engine.
interface fazyrv_alu_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [3:0]      req_op_i;
    logic [XLEN-1:0] req_a_i;
    logic [XLEN-1:0] req_b_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_res_o;
    logic            rsp_cmp_o;
    logic            rsp_illegal_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_res_o, rsp_cmp_o, rsp_illegal_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_res_o, rsp_cmp_o, rsp_illegal_o
    );
endinterface

// File: rtl/fazyrv_alu_seq.sv
// Chunked ALU engine. Accepts a full-width operand pair, walks it LSB-first in
// CHUNKSIZE-bit slices over ITERATIONS cycles, and presents the full-width result
// and compare flag until the response handshake completes.
// Ports:
//   clk_i   : clock, rising edge
//   rst_in  : asynchronous active-low reset
//   bus     : request/response bundle (slave side)
//   busy_o  : high while an op is being processed or its response is pending
module fazyrv_alu_seq #(
    parameter int XLEN       = 32,
    parameter int CHUNKSIZE  = 8,
    parameter int ITERATIONS = XLEN / CHUNKSIZE
) (
    input  logic             clk_i,
    input  logic             rst_in,
    fazyrv_alu_seq_if.slave  bus,
    output logic             busy_o
);
    localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(ITERATIONS - 1);

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_LT   = 4'd3;
    localparam logic [3:0] OP_LTU  = 4'd4;
    localparam logic [3:0] OP_EQ   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ops that run the adder as a subtractor (b inverted, carry-in of 1).
    function automatic logic is_sub(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_LT) || (op == OP_LTU);
    endfunction

    // Ops whose result is only the compare flag.
    function automatic logic is_cmp(input logic [3:0] op);
        return (op == OP_LT) || (op == OP_LTU) || (op == OP_EQ);
    endfunction

    state_t          state_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [3:0]      op_r;
    logic [CNT_W-1:0] k_r;
    logic            carry_r;
    logic            eq_r;
    logic [XLEN-1:0] res_r;
    logic            ready_r;
    logic            valid_r;
    logic            cmp_r;
    logic            illegal_r;
    logic            busy_r;

    logic [CHUNKSIZE-1:0]      a_chunk_s;
    logic [CHUNKSIZE-1:0]      b_chunk_s;
    logic                      sub_s;
    logic [CHUNKSIZE:0]        sum_ext_s;
    logic [CHUNKSIZE-1:0]      res_chunk_s;
    logic                      eq_next_s;
    logic                      cmp_s;
    logic                      illegal_s;
    logic                      msb_s;
    logic [XLEN+CHUNKSIZE-1:0] res_cat_s;
    logic [XLEN-1:0]           res_shift_s;
    logic [XLEN-1:0]           final_res_s;

    // Operands shift right each chunk, so the current slice is always at the bottom.
    assign a_chunk_s = a_r[CHUNKSIZE-1:0];
    assign b_chunk_s = b_r[CHUNKSIZE-1:0];
    assign sub_s     = is_sub(op_r);
    assign sum_ext_s = {1'b0, a_chunk_s}
                     + {1'b0, b_chunk_s ^ {CHUNKSIZE{sub_s}}}
                     + {{CHUNKSIZE{1'b0}}, carry_r};
    assign eq_next_s = eq_r & (a_chunk_s == b_chunk_s);
    assign illegal_s = (op_r > OP_AND);
    assign msb_s     = (k_r == LAST_K);
    // New chunk enters at the top, older chunks slide down: after the last chunk
    // the first chunk sits at bit 0.
    assign res_cat_s   = {res_chunk_s, res_r};
    assign res_shift_s = res_cat_s[XLEN+CHUNKSIZE-1:CHUNKSIZE];

    // Per-chunk result slice for arithmetic and logic ops.
    always_comb begin
        res_chunk_s = {CHUNKSIZE{1'b0}};
        case (op_r)
            OP_PASS:        res_chunk_s = b_chunk_s;
            OP_ADD, OP_SUB: res_chunk_s = sum_ext_s[CHUNKSIZE-1:0];
            OP_XOR:         res_chunk_s = a_chunk_s ^ b_chunk_s;
            OP_OR:          res_chunk_s = a_chunk_s | b_chunk_s;
            OP_AND:         res_chunk_s = a_chunk_s & b_chunk_s;
            default:        res_chunk_s = {CHUNKSIZE{1'b0}};
        endcase
    end

    // Compare flag, meaningful only on the msb chunk.
    always_comb begin
        cmp_s = 1'b0;
        case (op_r)
            OP_LT: begin
                // Signs differ: a is less exactly when it is negative; otherwise the
                // sign of a-b decides.
                if (a_chunk_s[CHUNKSIZE-1] != b_chunk_s[CHUNKSIZE-1]) begin
                    cmp_s = a_chunk_s[CHUNKSIZE-1];
                end else begin
                    cmp_s = sum_ext_s[CHUNKSIZE-1];
                end
            end
            OP_LTU:  cmp_s = ~sum_ext_s[CHUNKSIZE];
            OP_EQ:   cmp_s = eq_next_s;
            default: cmp_s = 1'b0;
        endcase
    end

    // Value presented on the response port once the last chunk is done.
    always_comb begin
        final_res_s = {XLEN{1'b0}};
        if (illegal_s) begin
            final_res_s = {XLEN{1'b0}};
        end else if (is_cmp(op_r)) begin
            final_res_s = {{(XLEN-1){1'b0}}, cmp_s};
        end else begin
            final_res_s = res_shift_s;
        end
    end

    // Sequencer and datapath state; all outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_r   <= IDLE;
            a_r       <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            op_r      <= 4'd0;
            k_r       <= {CNT_W{1'b0}};
            carry_r   <= 1'b0;
            eq_r      <= 1'b0;
            res_r     <= {XLEN{1'b0}};
            ready_r   <= 1'b0;
            valid_r   <= 1'b0;
            cmp_r     <= 1'b0;
            illegal_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b1;
                    if (bus.req_valid_i && ready_r) begin
                        a_r       <= bus.req_a_i;
                        b_r       <= bus.req_b_i;
                        op_r      <= bus.req_op_i;
                        k_r       <= {CNT_W{1'b0}};
                        carry_r   <= is_sub(bus.req_op_i);
                        eq_r      <= 1'b1;
                        res_r     <= {XLEN{1'b0}};
                        cmp_r     <= 1'b0;
                        illegal_r <= 1'b0;
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= RUN;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> CHUNKSIZE;
                    b_r     <= b_r >> CHUNKSIZE;
                    carry_r <= sum_ext_s[CHUNKSIZE];
                    eq_r    <= eq_next_s;
                    k_r     <= k_r + CNT_W'(1);
                    if (msb_s) begin
                        res_r     <= final_res_s;
                        cmp_r     <= cmp_s;
                        illegal_r <= illegal_s;
                        valid_r   <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        res_r     <= res_shift_s;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready_i) begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o   = ready_r;
    assign bus.rsp_valid_o   = valid_r;
    assign bus.rsp_res_o     = res_r;
    assign bus.rsp_cmp_o     = cmp_r;
    assign bus.rsp_illegal_o = illegal_r;
    assign busy_o            = busy_r;
endmodule

// File: tb/tb_fazyrv_alu_seq.sv
// Directed bench for fazyrv_alu_seq: a CHUNKSIZE=8 instance carries the detailed
// protocol checks; CHUNKSIZE 1, 4 and 32 instances run an ADD/LT sweep side by side.
module tb_fazyrv_alu_seq;
    logic clk = 1'b0;
    logic rst_in;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fazyrv_alu_seq_if #(.XLEN(32)) bus8 ();
    fazyrv_alu_seq_if #(.XLEN(32)) bus1 ();
    fazyrv_alu_seq_if #(.XLEN(32)) bus4 ();
    fazyrv_alu_seq_if #(.XLEN(32)) bus32 ();
    logic busy8, busy1, busy4, busy32;

    fazyrv_alu_seq #(.XLEN(32), .CHUNKSIZE(8))  dut8  (.clk_i(clk), .rst_in(rst_in), .bus(bus8),  .busy_o(busy8));
    fazyrv_alu_seq #(.XLEN(32), .CHUNKSIZE(1))  dut1  (.clk_i(clk), .rst_in(rst_in), .bus(bus1),  .busy_o(busy1));
    fazyrv_alu_seq #(.XLEN(32), .CHUNKSIZE(4))  dut4  (.clk_i(clk), .rst_in(rst_in), .bus(bus4),  .busy_o(busy4));
    fazyrv_alu_seq #(.XLEN(32), .CHUNKSIZE(32)) dut32 (.clk_i(clk), .rst_in(rst_in), .bus(bus32), .busy_o(busy32));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the 8-bit instance to be ready, then present one request.
    task automatic send8(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (bus8.req_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_send", {31'b0, bus8.req_ready_o}, 32'd1);
        bus8.req_op_i    = op;
        bus8.req_a_i     = a;
        bus8.req_b_i     = b;
        bus8.req_valid_i = 1'b1;
        @(posedge clk); #1;
        bus8.req_valid_i = 1'b0;
    endtask

    // Called #1 after the accept edge: response must appear exactly 4 edges later.
    task automatic wait_rsp8(input string tag, input logic [31:0] res, input logic cmp, input logic ill);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_valid_early"}, {31'b0, bus8.rsp_valid_o}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, {31'b0, bus8.rsp_valid_o}, 32'd1);
        chk({tag, "_res"}, bus8.rsp_res_o, res);
        chk({tag, "_cmp"}, {31'b0, bus8.rsp_cmp_o}, {31'b0, cmp});
        chk({tag, "_illegal"}, {31'b0, bus8.rsp_illegal_o}, {31'b0, ill});
        chk({tag, "_busy"}, {31'b0, busy8}, 32'd1);
        bus8.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus8.rsp_ready_i = 1'b0;
        chk({tag, "_valid_after"}, {31'b0, bus8.rsp_valid_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] va [0:7];
        logic [31:0] vb [0:7];
        logic [31:0] exp_res;
        logic [31:0] r1, r4, r32;
        int lat1, lat4, lat32;
        logic got1, got4, got32;
        logic seen_valid;

        rst_in = 1'b0;
        bus8.req_valid_i = 1'b0;  bus8.req_op_i = 4'd0;  bus8.req_a_i = 32'd0;  bus8.req_b_i = 32'd0;  bus8.rsp_ready_i = 1'b0;
        bus1.req_valid_i = 1'b0;  bus1.req_op_i = 4'd0;  bus1.req_a_i = 32'd0;  bus1.req_b_i = 32'd0;  bus1.rsp_ready_i = 1'b1;
        bus4.req_valid_i = 1'b0;  bus4.req_op_i = 4'd0;  bus4.req_a_i = 32'd0;  bus4.req_b_i = 32'd0;  bus4.rsp_ready_i = 1'b1;
        bus32.req_valid_i = 1'b0; bus32.req_op_i = 4'd0; bus32.req_a_i = 32'd0; bus32.req_b_i = 32'd0; bus32.rsp_ready_i = 1'b1;

        // Reset values
        #12;
        chk("rst_ready", {31'b0, bus8.req_ready_o}, 32'd0);
        chk("rst_valid", {31'b0, bus8.rsp_valid_o}, 32'd0);
        chk("rst_res", bus8.rsp_res_o, 32'd0);
        chk("rst_cmp", {31'b0, bus8.rsp_cmp_o}, 32'd0);
        chk("rst_illegal", {31'b0, bus8.rsp_illegal_o}, 32'd0);
        chk("rst_busy", {31'b0, busy8}, 32'd0);
        rst_in = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", {31'b0, bus8.req_ready_o}, 32'd1);

        // Main function, directed vectors
        send8(4'd1, 32'h0000_00FF, 32'h0000_0001); wait_rsp8("add_carry", 32'h0000_0100, 1'b0, 1'b0);
        send8(4'd2, 32'h0000_0000, 32'h0000_0001); wait_rsp8("sub",       32'hFFFF_FFFF, 1'b0, 1'b0);
        send8(4'd3, 32'hFFFF_FFFF, 32'h0000_0001); wait_rsp8("lt",        32'h0000_0001, 1'b1, 1'b0);
        send8(4'd4, 32'hFFFF_FFFF, 32'h0000_0001); wait_rsp8("ltu",       32'h0000_0000, 1'b0, 1'b0);
        send8(4'd5, 32'h1234_5678, 32'h1234_5678); wait_rsp8("eq_true",   32'h0000_0001, 1'b1, 1'b0);
        send8(4'd5, 32'h1234_5678, 32'h1234_5679); wait_rsp8("eq_false",  32'h0000_0000, 1'b0, 1'b0);
        send8(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00); wait_rsp8("xor",       32'h0FF0_0FF0, 1'b0, 1'b0);
        send8(4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00); wait_rsp8("or",        32'hFFF0_FFF0, 1'b0, 1'b0);
        send8(4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00); wait_rsp8("and",       32'hF000_F000, 1'b0, 1'b0);
        send8(4'd0, 32'h1111_1111, 32'hCAFE_BABE); wait_rsp8("pass",      32'hCAFE_BABE, 1'b0, 1'b0);
        send8(4'd3, 32'h8000_0000, 32'h7FFF_FFFF); wait_rsp8("lt_minint", 32'h0000_0001, 1'b1, 1'b0);
        send8(4'd4, 32'h0000_0001, 32'h8000_0000); wait_rsp8("ltu_small", 32'h0000_0001, 1'b1, 1'b0);
        send8(4'd12, 32'hDEAD_BEEF, 32'h0000_0001); wait_rsp8("illegal",  32'h0000_0000, 1'b0, 1'b1);
        send8(4'd1, 32'h0000_0001, 32'h0000_0001); wait_rsp8("post_illegal", 32'h0000_0002, 1'b0, 1'b0);

        // Back-pressure: response held 10 cycles with a second request pending
        send8(4'd1, 32'h0000_0010, 32'h0000_0020);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_valid", {31'b0, bus8.rsp_valid_o}, 32'd1);
        bus8.req_op_i    = 4'd7;
        bus8.req_a_i     = 32'h0000_000F;
        bus8.req_b_i     = 32'h0000_00F0;
        bus8.req_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_res", bus8.rsp_res_o, 32'h0000_0030);
            chk("bp_hold_flags", {29'b0, bus8.rsp_valid_o, bus8.req_ready_o, busy8}, 32'b101);
        end
        bus8.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus8.rsp_ready_i = 1'b0;
        chk("bp_after_hs", {30'b0, bus8.rsp_valid_o, bus8.req_ready_o}, 32'b01);
        @(posedge clk); #1;
        bus8.req_valid_i = 1'b0;
        chk("bp_second_accepted", {30'b0, bus8.req_ready_o, busy8}, 32'b01);
        wait_rsp8("bp_second", 32'h0000_00FF, 1'b0, 1'b0);

        // Reset during chunk 2: everything clears, no response
        send8(4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;
        #1;
        chk("midrst_outputs",
            {27'b0, bus8.req_ready_o, bus8.rsp_valid_o, bus8.rsp_cmp_o, bus8.rsp_illegal_o, busy8}, 32'd0);
        chk("midrst_res", bus8.rsp_res_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus8.rsp_valid_o !== 1'b0) seen_valid = 1'b1;
        end
        chk("midrst_no_response", {31'b0, seen_valid}, 32'd0);
        send8(4'd1, 32'd5, 32'd7); wait_rsp8("post_rst_add", 32'd12, 1'b0, 1'b0);

        // ADD/LT sweep on CHUNKSIZE 1, 4, 32 against a reference model
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001;
        va[1] = 32'h8000_0000; vb[1] = 32'h7FFF_FFFF;
        for (int i = 2; i < 8; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 2; j++) begin
                logic [3:0] op;
                op = (j == 0) ? 4'd1 : 4'd3;
                exp_res = (j == 0) ? (va[i] + vb[i]) : {31'b0, ($signed(va[i]) < $signed(vb[i]))};
                chk("sweep_ready", {29'b0, bus1.req_ready_o, bus4.req_ready_o, bus32.req_ready_o}, 32'b111);
                bus1.req_op_i = op;  bus1.req_a_i = va[i];  bus1.req_b_i = vb[i];  bus1.req_valid_i = 1'b1;
                bus4.req_op_i = op;  bus4.req_a_i = va[i];  bus4.req_b_i = vb[i];  bus4.req_valid_i = 1'b1;
                bus32.req_op_i = op; bus32.req_a_i = va[i]; bus32.req_b_i = vb[i]; bus32.req_valid_i = 1'b1;
                @(posedge clk); #1;
                bus1.req_valid_i = 1'b0; bus4.req_valid_i = 1'b0; bus32.req_valid_i = 1'b0;
                got1 = 1'b0; got4 = 1'b0; got32 = 1'b0;
                lat1 = 0; lat4 = 0; lat32 = 0;
                r1 = 32'd0; r4 = 32'd0; r32 = 32'd0;
                for (int c = 1; c <= 36; c++) begin
                    @(posedge clk); #1;
                    if (!got1 && bus1.rsp_valid_o === 1'b1) begin got1 = 1'b1; lat1 = c; r1 = bus1.rsp_res_o; end
                    if (!got4 && bus4.rsp_valid_o === 1'b1) begin got4 = 1'b1; lat4 = c; r4 = bus4.rsp_res_o; end
                    if (!got32 && bus32.rsp_valid_o === 1'b1) begin got32 = 1'b1; lat32 = c; r32 = bus32.rsp_res_o; end
                end
                chk("sweep_cs1_res", r1, exp_res);
                chk("sweep_cs4_res", r4, exp_res);
                chk("sweep_cs32_res", r32, exp_res);
                if (i == 0) begin
                    chk("lat_cs1", 32'(lat1), 32'd32);
                    chk("lat_cs4", 32'(lat4), 32'd8);
                    chk("lat_cs32", 32'(lat32), 32'd1);
                end
            end
        end
        chk("sweep_idle_busy", {28'b0, busy1, busy4, busy32, busy8}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
